// File: rtl/block_pkg.sv
// Shared constants and types for the block_pipeline_n handshake buffer.
package block_pkg;

  localparam int PHASE_4 = 0;  // return-to-zero handshake
  localparam int PHASE_2 = 1;  // transition handshake

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RZ   = 2'd2
  } out_state_e;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchroniser for a single handshake line; STAGES=0 is a plain wire.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_flops
      logic [STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q[0] <= 1'b0;
        end else begin
          sync_q[0] <= d_i;
        end
      end

      for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sync_q[gi] <= 1'b0;
          end else begin
            sync_q[gi] <= sync_q[gi-1];
          end
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/block_pipeline_n.sv
// Handshake-decoupled FIFO: an upstream req/ack port fills a small buffer and
// an output FSM replays it downstream, in 4-phase or 2-phase signalling.
module block_pipeline_n
  import block_pkg::*;
#(
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int PHASE_MODE  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ack_out,
  output logic                         req_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         ack_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int  PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int  CW        = $clog2(DEPTH + 1);
  localparam bit  TWO_PHASE = (PHASE_MODE == PHASE_2);

  logic req_s;
  logic ack_s;

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (req_in),
    .q_o   (req_s)
  );

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  ack_out_q;
  logic                  req_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  out_state_e            state_q;

  logic full;
  logic in_event;
  logic out_ack;
  logic push;
  logic pop;

  assign full     = (count_q == CW'(DEPTH));
  assign in_event = TWO_PHASE ? (req_s != ack_out_q) : (req_s && !ack_out_q);
  assign out_ack  = TWO_PHASE ? (ack_s == req_out_q) : ack_s;
  assign pop      = (state_q == ST_REQ) && out_ack;
  // A full buffer still accepts when the head leaves on the same edge.
  assign push     = in_event && (!full || pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_out_q <= 1'b0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        ack_out_q <= TWO_PHASE ? ~ack_out_q : 1'b1;
        wr_ptr_q  <= wr_ptr_q + 1'b1;
      end else if (!TWO_PHASE && !req_s) begin
        ack_out_q <= 1'b0;
      end
    end
  end

  // Output FSM; an empty buffer forwards a same-edge push straight to data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_out_q  <= 1'b0;
      data_out_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((count_q != '0 || push) && (TWO_PHASE || !ack_s)) begin
            data_out_q <= (count_q != '0) ? mem_q[rd_ptr_q] : data_in;
            req_out_q  <= TWO_PHASE ? ~req_out_q : 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (out_ack) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (TWO_PHASE) begin
              state_q <= ST_IDLE;
            end else begin
              req_out_q <= 1'b0;
              state_q   <= ST_RZ;
            end
          end
        end
        ST_RZ: begin
          if (!ack_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_out  = ack_out_q;
  assign req_out  = req_out_q;
  assign data_out = data_out_q;
  assign count    = count_q;

endmodule
